layer_seq_ctrl: RTL

LAYER_SEQ_CTRL -- requirements
Module: layer_seq_ctrl

---
 rtl/layer_seq_ctrl_if.sv | 32 +++
 rtl/layer_seq_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/layer_seq_ctrl_if.sv
// Bundle between one neuron layer and the next: parallel capture in, serial words out.
// Carries the capture strobe/data, the serial stream, status flags and argmax result.
// No backpressure: the consuming layer must accept one word per cycle while x_valid is high.
interface layer_seq_ctrl_if #(
  parameter int NN        = 10,
  parameter int dataWidth = 16
);
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;

  logic [NN-1:0]           o_valid;
  logic [NN*dataWidth-1:0] x_out;
  logic                    x_valid;
  logic [dataWidth-1:0]    x_in;
  logic                    busy;
  logic                    layer_done;
  logic                    overrun;
  logic                    sync_err;
  logic [IW-1:0]           class_idx;
  logic                    class_valid;

  // Sequencer side
  modport master (
    input  o_valid, x_out,
    output x_valid, x_in, busy, layer_done, overrun, sync_err, class_idx, class_valid
  );

  // Layer / environment side
  modport slave (
    output o_valid, x_out,
    input  x_valid, x_in, busy, layer_done, overrun, sync_err, class_idx, class_valid
  );
endinterface

// File: rtl/layer_seq_ctrl.sv
// Captures NN parallel neuron outputs and replays them as NN back-to-back serial words.
// Latency: first word one cycle after capture; optional argmax (SEQ_ARGMAX_EN) one cycle after layer_done.
// No backpressure: captures arriving mid-burst are dropped and flagged via sticky overrun.
module layer_seq_ctrl #(
  parameter int NN        = 10,
  parameter int dataWidth = 16
) (
  input logic               clk,
  input logic               rst,
  layer_seq_ctrl_if.master  bus
);
  localparam int CW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CW-1:0] LAST = CW'(NN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nxt;
  logic [dataWidth-1:0] x_in_q;
  logic                 layer_done_q;
  logic                 overrun_q;
  logic                 sync_err_q;
  logic                 last_word;
  logic                 accept;
  logic [dataWidth-1:0] word_buf [NN];

  assign cnt_nxt   = cnt + 1'b1;
  assign last_word = (state == SEND) && (cnt == LAST);
  // A new layer is taken only when idle or on the final word of the current burst.
  assign accept    = bus.o_valid[0] && ((state == IDLE) || last_word);

  // Snapshot the producing layer's outputs on every accepted capture only
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int k = 0; k < NN; k++) begin
        word_buf[k] <= bus.x_out[k*dataWidth +: dataWidth];
      end
    end
  end

  // Burst sequencer: IDLE waits for a capture, SEND walks the buffer one word per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      x_in_q       <= '0;
      layer_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      layer_done_q <= 1'b0;
      if (accept) begin
        // Word 0 is taken straight from x_out so it can appear the very next cycle.
        state        <= SEND;
        cnt          <= '0;
        x_in_q       <= bus.x_out[dataWidth-1:0];
        layer_done_q <= (NN == 1);
        if (!(&bus.o_valid)) sync_err_q <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            x_in_q <= '0;
          end
          SEND: begin
            if (last_word) begin
              state  <= IDLE;
              cnt    <= '0;
              x_in_q <= '0;
            end else begin
              cnt          <= cnt_nxt;
              x_in_q       <= word_buf[cnt_nxt];
              layer_done_q <= (cnt_nxt == LAST);
              if (bus.o_valid[0]) overrun_q <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.x_valid    = (state == SEND);
  assign bus.busy       = (state == SEND);
  assign bus.x_in       = x_in_q;
  assign bus.layer_done = layer_done_q;
  assign bus.overrun    = overrun_q;
  assign bus.sync_err   = sync_err_q;

`ifdef SEQ_ARGMAX_EN
  logic signed [dataWidth-1:0] run_max;
  logic signed [dataWidth-1:0] cur_word;
  logic [CW-1:0]               run_idx;
  logic [CW-1:0]               cls_idx_q;
  logic                        cls_vld_q;
  logic                        take;

  assign cur_word = x_in_q;
  // Strict compare so a tie keeps the earlier (lower) index.
  assign take     = (cnt == '0) || (cur_word > run_max);

  // Fold each emitted word into the running max; publish the winner after the last word
  always_ff @(posedge clk) begin
    if (rst) begin
      run_max   <= '0;
      run_idx   <= '0;
      cls_idx_q <= '0;
      cls_vld_q <= 1'b0;
    end else begin
      cls_vld_q <= 1'b0;
      if (state == SEND) begin
        if (take) begin
          run_max <= cur_word;
          run_idx <= cnt;
        end
        if (cnt == LAST) begin
          cls_vld_q <= 1'b1;
          cls_idx_q <= take ? cnt : run_idx;
        end
      end
    end
  end

  assign bus.class_idx   = cls_idx_q;
  assign bus.class_valid = cls_vld_q;
`else
  assign bus.class_idx   = '0;
  assign bus.class_valid = 1'b0;
`endif

endmodule
